// File: rtl/hsv_core_pkg.sv
// Shared core types; holds the flush sequencer state encoding.
// Optional flush watchdog is enabled with HSV_FLUSH_WATCHDOG_EN.
package hsv_core_pkg;

    localparam int FLUSH_TARGET_W = 32;

    localparam logic [1:0] FLUSH_ST_IDLE  = 2'd0;
    localparam logic [1:0] FLUSH_ST_RAISE = 2'd1;
    localparam logic [1:0] FLUSH_ST_FALL  = 2'd2;

    typedef enum logic [1:0] {
        FLUSH_IDLE  = FLUSH_ST_IDLE,
        FLUSH_RAISE = FLUSH_ST_RAISE,
        FLUSH_FALL  = FLUSH_ST_FALL
    } flush_seq_state_t;

endpackage

// File: rtl/hsv_core_flush_watchdog.sv
// Per-phase timeout counter and stuck-stage capture for the flush sequencer.
// Only instantiated when HSV_FLUSH_WATCHDOG_EN is defined.
module hsv_core_flush_watchdog
    import hsv_core_pkg::*;
#(
    parameter int NUM_ACKS       = 9,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_core,
    input  logic                 rst_core,
    input  flush_seq_state_t     state,
    input  flush_seq_state_t     state_next,
    input  logic [NUM_ACKS-1:0]  flush_acks,
    output logic                 expire,
    output logic                 timeout_o,
    output logic [NUM_ACKS-1:0]  stuck_mask_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    cnt_next;
    logic                timeout_reg;
    logic [NUM_ACKS-1:0] stuck_reg;
    logic [NUM_ACKS-1:0] stuck_next;
    logic                in_phase;
    logic                exit_met;

    assign in_phase = (state != FLUSH_IDLE);
    assign exit_met = ((state == FLUSH_RAISE) && (&flush_acks)) ||
                      ((state == FLUSH_FALL)  && !(|flush_acks));

    // A normal exit in the terminal cycle takes priority over the timeout.
    assign expire = in_phase && (cnt_reg == CNT_MAX) && !exit_met;

    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state) begin
            cnt_next = '0;
        end else if (in_phase) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Stuck stages: still low when waiting for rise, still high when waiting for fall.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ACKS; gi++) begin : g_stuck
            assign stuck_next[gi] = expire
                ? ((state == FLUSH_RAISE) ? ~flush_acks[gi] : flush_acks[gi])
                : stuck_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
            stuck_reg   <= '0;
        end else begin
            cnt_reg     <= cnt_next;
            timeout_reg <= expire;
            stuck_reg   <= stuck_next;
        end
    end

    assign timeout_o    = timeout_reg;
    assign stuck_mask_o = stuck_reg;

endmodule

// File: rtl/hsv_core_flush_sequencer.sv
// Core-wide flush handshake: raise flush_req until all stages ack, then wait for all acks to drop.
// Define HSV_FLUSH_WATCHDOG_EN to add a per-phase timeout with stuck-stage reporting.
module hsv_core_flush_sequencer
    import hsv_core_pkg::*;
#(
    parameter int NUM_ACKS       = 9,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk_core,
    input  logic                       rst_core,
    input  logic                       start_valid_i,
    output logic                       start_ready_o,
    input  logic [FLUSH_TARGET_W-1:0]  start_target_i,
    output logic                       flush_req,
    output logic [FLUSH_TARGET_W-1:0]  flush_target,
    input  logic [NUM_ACKS-1:0]        flush_acks,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       timeout_o,
    output logic [NUM_ACKS-1:0]        stuck_mask_o
);

    generate
        if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
            $error("hsv_core_flush_sequencer: TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    flush_seq_state_t            state_reg;
    flush_seq_state_t            state_next;
    logic                        accept;
    logic                        done_next;
    logic                        wd_expire;
    logic                        ready_reg;
    logic                        busy_reg;
    logic                        req_reg;
    logic                        done_reg;
    logic [FLUSH_TARGET_W-1:0]   target_reg;

`ifdef HSV_FLUSH_WATCHDOG_EN
    hsv_core_flush_watchdog #(
        .NUM_ACKS       (NUM_ACKS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_core     (clk_core),
        .rst_core     (rst_core),
        .state        (state_reg),
        .state_next   (state_next),
        .flush_acks   (flush_acks),
        .expire       (wd_expire),
        .timeout_o    (timeout_o),
        .stuck_mask_o (stuck_mask_o)
    );
`else
    assign wd_expire    = 1'b0;
    assign timeout_o    = 1'b0;
    assign stuck_mask_o = '0;
`endif

    assign accept = (state_reg == FLUSH_IDLE) && start_valid_i;

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            FLUSH_IDLE: begin
                if (start_valid_i) begin
                    state_next = FLUSH_RAISE;
                end
            end
            FLUSH_RAISE: begin
                if ((&flush_acks) || wd_expire) begin
                    state_next = FLUSH_FALL;
                end
            end
            FLUSH_FALL: begin
                if (!(|flush_acks) || wd_expire) begin
                    state_next = FLUSH_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = FLUSH_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they align with the state.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state_reg  <= FLUSH_IDLE;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            req_reg    <= 1'b0;
            done_reg   <= 1'b0;
            target_reg <= '0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == FLUSH_IDLE);
            busy_reg  <= (state_next != FLUSH_IDLE);
            req_reg   <= (state_next == FLUSH_RAISE);
            done_reg  <= done_next;
            if (accept) begin
                target_reg <= start_target_i;
            end
        end
    end

    assign start_ready_o = ready_reg;
    assign busy_o        = busy_reg;
    assign flush_req     = req_reg;
    assign done_o        = done_reg;
    assign flush_target  = target_reg;

endmodule

// File: doc/hsv_core_flush_sequencer.md
# hsv_core_flush_sequencer

Sequences the core-wide pipeline flush handshake on behalf of the control/status FSM. Accepts a flush command with a redirect target, raises `flush_req`, waits until every pipeline stage acknowledges, drops the request, and waits until every acknowledgement has fallen. It then reports completion. It sits beside the global control FSM in the ctrlstatus unit and drives the `flush_req`/`flush_target` nets seen by all stages.

## Interface
- `NUM_ACKS`, default 9: number of stage flush acknowledgements.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit per phase; must be ≥ 2. Used only when the watchdog is compiled in.
- `clk_core` in 1: core clock.
- `rst_core` in 1: reset; one clock; reset is synchronous and active-high.
- `start_valid_i` in 1: flush command valid.
- `start_ready_o` out 1: sequencer idle, command accepted on `start_valid_i & start_ready_o`.
- `start_target_i` in 32: redirect PC for the flush.
- `flush_req` out 1: flush request to all stages.
- `flush_target` out 32: latched redirect PC, stable while busy.
- `flush_acks` in NUM_ACKS: per-stage acknowledgements.
- `busy_o` out 1: sequence in progress.
- `done_o` out 1: one-cycle completion pulse.
- `timeout_o` out 1: one-cycle watchdog pulse.
- `stuck_mask_o` out NUM_ACKS: stages that failed the last timed-out phase.

## Operation
- States: IDLE, RAISE, FALL.
- IDLE:
  - `start_ready_o`=1.
  - On accept, latch `start_target_i` into `flush_target` and go to RAISE.
  - `flush_acks` is ignored in IDLE.
- RAISE:
  - `flush_req`=1.
  - When `&flush_acks` is sampled 1, go to FALL.
- FALL:
  - `flush_req`=0.
  - When `|flush_acks` is sampled 0, go to IDLE and pulse `done_o`.
- `busy_o` = (state != IDLE).
- `flush_target` holds its value after completion until the next accept.
- `start_valid_i` while busy is ignored. The command is not queued; the requester holds it until `start_ready_o`.
- Acks that are already all-1 in the first RAISE cycle satisfy RAISE immediately.
- Acks that are already all-0 in the first FALL cycle satisfy FALL immediately.
- Reset mid-sequence forces IDLE on the next edge. `flush_req` drops and no `done_o` is generated.

## Timing
- Reset values:
  - `start_ready_o`=1, `busy_o`=0.
  - `flush_req`=0, `flush_target`=0.
  - `done_o`=0, `timeout_o`=0, `stuck_mask_o`=0.
- Command accepted at edge N: `flush_req`=1 and `busy_o`=1 from cycle N+1.
- All acks high sampled at edge M: `flush_req`=0 from cycle M+1.
- All acks low sampled at edge K: `done_o`=1 during cycle K+1 only, and `start_ready_o`=1 from cycle K+1.
- A new command may be accepted at edge K+1 (back-to-back).
- Minimum sequence: 3 cycles from accept to `done_o`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `HSV_FLUSH_WATCHDOG_EN`.
- Defined:
  - A phase counter, width `$clog2(TIMEOUT_CYCLES)`, clears on every state change and counts in RAISE and FALL.
  - When it reaches TIMEOUT_CYCLES-1 with the exit condition still unmet:
    - pulse `timeout_o`;
    - latch `stuck_mask_o` = `~flush_acks` in RAISE, or `flush_acks` in FALL;
    - force the next state (RAISE→FALL, FALL→IDLE with `done_o` pulse).
  - If the exit condition holds in the same cycle, normal exit wins and there is no timeout.
  - `stuck_mask_o` holds until the next timeout or reset.
- Undefined:
  - No counter.
  - `timeout_o` and `stuck_mask_o` are tied to 0.
  - Phases wait indefinitely.

## Structure
- `hsv_core_pkg` gains `flush_seq_state_t` (IDLE, RAISE, FALL).
- Single module, plus one sub-module `hsv_core_flush_watchdog`, which holds the counter and mask capture and is instantiated only under the macro.

## Test plan
- Basic flush:
  - Stimulus: reset, start with target 0x8000_0100; all 9 acks rise 2 cycles after `flush_req`, fall 2 cycles after it drops.
  - Required: `flush_target`=0x8000_0100; `done_o` is a single pulse 7 cycles after accept; `busy_o` deasserted with it.
- Staggered acks:
  - Stimulus: acks rise one stage per cycle.
  - Required: `flush_req` stays 1 until the cycle after the 9th ack; FALL is not exited while any ack remains high.
- Busy collision:
  - Stimulus: second start with target 0x1234 during RAISE.
  - Required: `start_ready_o`=0 and `flush_target` unchanged. Holding valid gives acceptance in the `done_o` cycle, and the new target is latched.
- Reset mid-flush:
  - Stimulus: assert `rst_core` in RAISE.
  - Required: next cycle `flush_req`=0, `busy_o`=0, `start_ready_o`=1; no `done_o`.
- Watchdog (macro on, `TIMEOUT_CYCLES`=16):
  - Stimulus: ack bit 3 held 0.
  - Required: `timeout_o` pulses 16 cycles after entering RAISE; `stuck_mask_o`=0x008; FALL then completes normally.
- Watchdog off:
  - Stimulus: same as the watchdog scenario.
  - Required: stays in RAISE for ≥100 cycles; `timeout_o` is never asserted.
